// File: rtl/load_store_unit_if.sv
// Core/memory-facing bundle for load_store_unit: request/response handshake plus word memory port.
// slave = the LSU itself; master = the core and data memory surrounding it.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed RV32I load/store front end for a word-indexed data memory (SB/SH via read-modify-write).
// Define LSU_MISALIGN_TRAP_EN to report misaligned H/HU/W accesses as errors instead of masking them.
module load_store_unit #(
    parameter int DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] store_q;

    logic        req_ready_r;
    logic        resp_valid_r;
    logic        resp_err_r;
    logic [31:0] resp_rdata_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;

    logic        req_err;
    logic [1:0]  req_lane;
    logic [31:0] word_idx;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    // Misalignment is detected as "natural alignment had to change the low address bits".
    always_comb begin
        word_idx = {2'b00, bus.req_addr[31:2]};
        req_lane = bus.req_addr[1:0];
        req_err  = 1'b0;
        case (bus.req_funct3)
            3'b000: req_err = 1'b0;
            3'b001: req_lane[0] = 1'b0;
            3'b010: req_lane = 2'b00;
            3'b100: req_err = bus.req_we;
            3'b101: begin
                req_lane[0] = 1'b0;
                req_err     = bus.req_we;
            end
            default: req_err = 1'b1;
        endcase
        if (word_idx >= 32'(DEPTH)) req_err = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_lane != bus.req_addr[1:0]) req_err = 1'b1;
`endif
    end

    always_comb begin
        case (lane_q)
            2'd0:    sel_byte = bus.mem_rdata[7:0];
            2'd1:    sel_byte = bus.mem_rdata[15:8];
            2'd2:    sel_byte = bus.mem_rdata[23:16];
            default: sel_byte = bus.mem_rdata[31:24];
        endcase
        sel_half = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_data = {24'd0, sel_byte};
            3'b101:  load_data = {16'd0, sel_half};
            default: load_data = bus.mem_rdata;
        endcase

        merged_word = bus.mem_rdata;
        if (funct3_q[0]) begin
            if (lane_q[1]) merged_word[31:16] = store_q;
            else           merged_word[15:0]  = store_q;
        end else begin
            case (lane_q)
                2'd0:    merged_word[7:0]   = store_q[7:0];
                2'd1:    merged_word[15:8]  = store_q[7:0];
                2'd2:    merged_word[23:16] = store_q[7:0];
                default: merged_word[31:24] = store_q[7:0];
            endcase
        end
    end

    // The memory write register doubles as the RMW word buffer, so the merge happens as RD exits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            lane_q       <= 2'd0;
            store_q      <= 16'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= 32'd0;
            mem_wdata_r  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        funct3_q    <= bus.req_funct3;
                        lane_q      <= req_lane;
                        store_q     <= bus.req_wdata[15:0];
                        req_ready_r <= 1'b0;
                        if (req_err) begin
                            state        <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'd0;
                        end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
                            state       <= WR;
                            mem_write_r <= 1'b1;
                            mem_addr_r  <= word_idx;
                            mem_wdata_r <= bus.req_wdata;
                        end else begin
                            state      <= RD;
                            mem_read_r <= 1'b1;
                            mem_addr_r <= word_idx;
                        end
                    end
                end
                RD: begin
                    mem_read_r <= 1'b0;
                    if (we_q) begin
                        state       <= WR;
                        mem_write_r <= 1'b1;
                        mem_wdata_r <= merged_word;
                    end else begin
                        state        <= RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= load_data;
                    end
                end
                WR: begin
                    mem_write_r  <= 1'b0;
                    state        <= RESP;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'd0;
                end
                RESP: begin
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.mem_read   = mem_read_r;
    assign bus.mem_write  = mem_write_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;

endmodule
